// File: rtl/key_switch_pkg.sv
// Shared constants and types for the key/switch input peripheral.
package key_switch_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NKEYS  = 4;

  typedef enum logic [1:0] {
    ADDR_SW   = 2'd0,
    ADDR_KEY  = 2'd1,
    ADDR_FLAG = 2'd2,
    ADDR_MASK = 2'd3
  } addr_e;

  typedef logic [NKEYS-1:0]  keyvec_t;
  typedef logic [DATA_W-1:0] data_t;

  function automatic data_t pad_keys(input keyvec_t v);
    return {{(DATA_W-NKEYS){1'b0}}, v};
  endfunction

endpackage

// File: rtl/key_switch_port_if.sv
// CPU-side register port of the key/switch peripheral.
interface key_switch_port_if;
  import key_switch_pkg::*;

  logic [1:0] addr;
  logic       rd_en;
  logic       wr_en;
  data_t      wdata;
  data_t      rdata;
  logic       irq;

  modport master (
    output addr, rd_en, wr_en, wdata,
    input  rdata, irq
  );

  modport slave (
    input  addr, rd_en, wr_en, wdata,
    output rdata, irq
  );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce counter, stable level and press pulse.
module key_debounce #(
  parameter  int unsigned DEBOUNCE_CYCLES = 4,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_i,
  output logic stable_o,
  output logic rise_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             kp;
  logic             expire;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // Buttons are active-low on the board; kp is 1 while pressed.
  assign kp     = ~sync2_q;
  assign expire = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (kp != stable_q) begin
      if (expire) begin
        stable_d = kp;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign stable_o = stable_q;
  // High during the cycle whose closing edge takes stable from 0 to 1.
  assign rise_o   = kp & ~stable_q & expire;

endmodule

// File: rtl/key_switch_port.sv
// Memory-mapped switch/pushbutton port: synchronised inputs, sticky press flags, masked irq.
module key_switch_port
  import key_switch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NKEYS-1:0] key_raw,
  input  logic [DATA_W-1:0] sw_raw,
  key_switch_port_if.slave bus
);

  data_t   sw_s1_q, sw_s2_q;
  keyvec_t stable, rise;
  keyvec_t flag_q, flag_d;
  keyvec_t mask_q, mask_d;
  keyvec_t clr;
  data_t   rdata_q, rdata_d;
  addr_e   addr_sel;
  logic    unused_wdata;

  assign addr_sel     = addr_e'(bus.addr);
  assign unused_wdata = ^bus.wdata[DATA_W-1:NKEYS];

  for (genvar g = 0; g < NKEYS; g++) begin : gen_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .key_raw_i(key_raw[g]),
      .stable_o (stable[g]),
      .rise_o   (rise[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      flag_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      sw_s1_q <= sw_raw;
      sw_s2_q <= sw_s1_q;
      flag_q  <= flag_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    clr = '0;
    if (bus.rd_en && addr_sel == ADDR_FLAG) begin
      clr = '1;
    end
    if (bus.wr_en && addr_sel == ADDR_FLAG) begin
      clr = clr | bus.wdata[NKEYS-1:0];
    end
    // A press landing on the same edge as a clear must not be lost.
    flag_d = (flag_q & ~clr) | rise;

    mask_d = mask_q;
    if (bus.wr_en && addr_sel == ADDR_MASK) begin
      mask_d = bus.wdata[NKEYS-1:0];
    end

    rdata_d = rdata_q;
    if (bus.rd_en) begin
      case (addr_sel)
        ADDR_SW:   rdata_d = sw_s2_q;
        ADDR_KEY:  rdata_d = pad_keys(stable);
        ADDR_FLAG: rdata_d = pad_keys(flag_q);
        ADDR_MASK: rdata_d = pad_keys(mask_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = |(flag_q & mask_q);

endmodule

// File: tb/tb_key_switch_port.sv
// Self-checking bench for key_switch_port: fixed vectors, directed corner sequences, random traffic vs model.
`timescale 1ns/1ps
module tb_key_switch_port;
  import key_switch_pkg::*;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] key_raw = 4'hF;
  logic [7:0] sw_raw = 8'h00;

  key_switch_port_if bus();

  key_switch_port #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .key_raw(key_raw),
    .sw_raw (sw_raw),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [3:0] m_raw1, m_raw2;
  logic [7:0] m_sw1, m_sw2;
  logic [3:0] m_stable, m_flag, m_mask;
  logic [7:0] m_rdata;
  int         last_ok[4];
  int         ecnt = 0;

  typedef struct {
    logic [1:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] sw;
    logic [7:0] exp_rdata;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_irq();
    return |(m_flag & m_mask);
  endfunction

  task automatic model_reset();
    m_raw1 = 4'hF; m_raw2 = 4'hF;
    m_sw1 = 8'h00; m_sw2 = 8'h00;
    m_stable = 4'h0; m_flag = 4'h0; m_mask = 4'h0;
    m_rdata = 8'h00;
    for (int i = 0; i < 4; i++) last_ok[i] = ecnt;
  endtask

  // A key's level flips once it has disagreed with the accepted level for DEB
  // consecutive edges, measured from the last edge it agreed (or last flip/reset).
  task automatic model_edge();
    logic [3:0] kp, nst, rise, clr;
    ecnt++;
    kp  = ~m_raw2;
    nst = m_stable;
    for (int i = 0; i < 4; i++) begin
      if (kp[i] == m_stable[i]) last_ok[i] = ecnt;
      else if (ecnt - last_ok[i] >= int'(DEB)) begin
        nst[i] = kp[i];
        last_ok[i] = ecnt;
      end
    end
    rise = nst & ~m_stable;
    if (bus.rd_en) begin
      case (bus.addr)
        2'd0:    m_rdata = m_sw2;
        2'd1:    m_rdata = {4'h0, m_stable};
        2'd2:    m_rdata = {4'h0, m_flag};
        default: m_rdata = {4'h0, m_mask};
      endcase
    end
    clr = 4'h0;
    if (bus.rd_en && bus.addr == 2'd2) clr = 4'hF;
    if (bus.wr_en && bus.addr == 2'd2) clr = clr | bus.wdata[3:0];
    m_flag = (m_flag & ~clr) | rise;
    if (bus.wr_en && bus.addr == 2'd3) m_mask = bus.wdata[3:0];
    m_stable = nst;
    m_sw2 = m_sw1;  m_sw1 = sw_raw;
    m_raw2 = m_raw1; m_raw1 = key_raw;
  endtask

  // One clock: drive the bus, advance the model, compare after the edge.
  task automatic cyc(input logic [1:0] a, input logic rd, input logic wr, input logic [7:0] wd);
    bus.addr = a; bus.rd_en = rd; bus.wr_en = wr; bus.wdata = wd;
    model_edge();
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0; bus.wr_en = 1'b0;
    check("model_rdata", bus.rdata, m_rdata);
    check("model_irq", {7'b0, bus.irq}, {7'b0, m_irq()});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'd0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.addr = 2'd0; bus.rd_en = 1'b0; bus.wr_en = 1'b0; bus.wdata = 8'h00;

    vecs[0] = '{2'd1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[2] = '{2'd0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h00, 1'b0};
    vecs[3] = '{2'd0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h00, 1'b0};
    vecs[4] = '{2'd0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b0};
    vecs[5] = '{2'd3, 1'b1, 1'b1, 8'h0C, 8'hA5, 8'h00, 1'b0};
    vecs[6] = '{2'd3, 1'b1, 1'b0, 8'h00, 8'hA5, 8'h0C, 1'b0};
    vecs[7] = '{2'd0, 1'b0, 1'b1, 8'hFF, 8'hA5, 8'h0C, 1'b0};
    vecs[8] = '{2'd0, 1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5, 1'b0};
    vecs[9] = '{2'd3, 1'b0, 1'b1, 8'h00, 8'hA5, 8'hA5, 1'b0};

    // Reset held for three clocks.
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    model_reset();
    check("reset_rdata", bus.rdata, 8'h00);
    check("reset_irq", {7'b0, bus.irq}, 8'h00);

    for (int i = 0; i < 10; i++) begin
      sw_raw = vecs[i].sw;
      cyc(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata);
      check("vec_rdata", bus.rdata, vecs[i].exp_rdata);
      check("vec_irq", {7'b0, bus.irq}, {7'b0, vecs[i].exp_irq});
    end

    // Clean press of key 0: stable visible to a read at the 7th edge.
    key_raw = 4'hE;
    for (int k = 1; k <= 7; k++) begin
      cyc(2'd1, 1'b1, 1'b0, 8'h00);
      check("press_stable", bus.rdata, (k == 7) ? 8'h01 : 8'h00);
    end
    cyc(2'd2, 1'b1, 1'b0, 8'h00);
    check("press_flag", bus.rdata, 8'h01);
    cyc(2'd2, 1'b1, 1'b0, 8'h00);
    check("press_clr", bus.rdata, 8'h00);
    key_raw = 4'hF;
    idle(8);
    cyc(2'd2, 1'b1, 1'b0, 8'h00);
    check("release_noflag", bus.rdata, 8'h00);
    cyc(2'd1, 1'b1, 1'b0, 8'h00);
    check("release_stable", bus.rdata, 8'h00);

    // Bounce on key 1: 3 low, 2 high, 3 low.
    key_raw = 4'hD; idle(3);
    key_raw = 4'hF; idle(2);
    key_raw = 4'hD; idle(3);
    key_raw = 4'hF; idle(8);
    cyc(2'd1, 1'b1, 1'b0, 8'h00);
    check("bounce_key", bus.rdata, 8'h00);
    cyc(2'd2, 1'b1, 1'b0, 8'h00);
    check("bounce_flag", bus.rdata, 8'h00);

    // Interrupt path on key 2.
    cyc(2'd3, 1'b0, 1'b1, 8'h04);
    key_raw = 4'hB;
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      check("irq_rise", {7'b0, bus.irq}, (k == 6) ? 8'h01 : 8'h00);
    end
    cyc(2'd2, 1'b0, 1'b1, 8'h04);
    check("irq_w1c", {7'b0, bus.irq}, 8'h00);
    key_raw = 4'hF; idle(8);

    // Read of flags on the very edge key 3's press is accepted.
    key_raw = 4'h7;
    idle(5);
    cyc(2'd2, 1'b1, 1'b0, 8'h00);
    check("setwins_old", bus.rdata, 8'h00);
    cyc(2'd2, 1'b1, 1'b0, 8'h00);
    check("setwins_flag", bus.rdata, 8'h08);
    key_raw = 4'hF; idle(8);

    // Async reset while key 0 is two counts into qualification.
    key_raw = 4'hE;
    cyc(2'd0, 1'b1, 1'b0, 8'h00);
    check("pre_reset_sw", bus.rdata, 8'hA5);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    check("areset_rdata", bus.rdata, 8'h00);
    check("areset_irq", {7'b0, bus.irq}, 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(2'd1, 1'b1, 1'b0, 8'h00);
      check("requal_stable", bus.rdata, (k == 7) ? 8'h01 : 8'h00);
    end
    cyc(2'd3, 1'b1, 1'b0, 8'h00);
    check("reset_mask", bus.rdata, 8'h00);
    key_raw = 4'hF; idle(8);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] tog;
      for (int b = 0; b < 4; b++) tog[b] = ($urandom_range(0, 5) == 0);
      key_raw = key_raw ^ tog;
      if ($urandom_range(0, 15) == 0) sw_raw = 8'($urandom);
      cyc(2'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, 8'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        #2 reset_n = 1'b0;
        #1;
        check("rand_areset_rdata", bus.rdata, 8'h00);
        check("rand_areset_irq", {7'b0, bus.irq}, 8'h00);
        model_reset();
        #1 reset_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_switch_port.md
Name: key_switch_port

Overview:
- Memory-mapped input peripheral sitting directly upstream of the CPU core inside MyComputer.
- Synchronises the board switches SW[7:0]; synchronises and debounces the four pushbuttons KEY[3:0].
- Captures button-press events in sticky flags and raises an interrupt request.
- Serves all of this to the CPU over a simple 8-bit register read/write port.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a key change (set to 500000 for board builds).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- key_raw  in  4  board pushbuttons, active-low (0 = pressed), asynchronous.
- sw_raw  in  8  board slide switches SW[7:0], asynchronous.
- addr  in  2  CPU register address.
- rd_en  in  1  CPU read strobe, one cycle.
- wr_en  in  1  CPU write strobe, one cycle.
- wdata  in  8  CPU write data.
- rdata  out  8  read data, registered.
- irq  out  1  interrupt request, active-high.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n). All flops clear immediately when reset_n falls, independent of clk.
- Reset values:
  - key sync flops = 1 (released); sw sync flops = 0.
  - debounced key level = 0; debounce counters = 0.
  - edge flags = 0; irq mask = 0.
  - rdata = 0; irq = 0.
- Synchronisers: 2-flop synchroniser on every key_raw and sw_raw bit. Internal pressed signal kp[i] = ~key_sync[i].
- Debounce, per key, independent:
  - If kp[i] == stable[i], the counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the counter equals DEBOUNCE_CYCLES-1 and the mismatch persists, stable[i] <= kp[i] and the counter clears.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES cycles leaves stable unchanged.
  - Total latency from a key_raw change to a stable change: 2 + DEBOUNCE_CYCLES rising edges.
- Edge flags: flag[i] sets on the same edge that stable[i] goes 0->1. Releases (1->0) set nothing. Flags are sticky.
- Register map (read data; unused bits read 0):
  - 0: SW value.
  - 1: {4'b0, stable[3:0]}.
  - 2: {4'b0, flag[3:0]}.
  - 3: {4'b0, mask[3:0]}.
- Reads: rdata is registered. When rd_en is high at edge N, rdata holds the selected register value from before edge N, valid after edge N. When rd_en is low, rdata holds its previous value.
- Clear-on-read: a read of address 2 clears all flags at the same edge that captures them.
- Writes:
  - addr 2: write-1-to-clear on flag[3:0].
  - addr 3: mask <= wdata[3:0].
  - addr 0 and 1: writes are ignored.
- Simultaneous events:
  - A new press edge on key i in the same cycle as a clear (read or W1C) leaves flag[i] = 1. Set wins.
  - rd_en and wr_en together are both honoured. The read returns the pre-write value.
- irq = |(flag & mask), combinational from registers; asserts the cycle after the setting edge.
- Reset mid-debounce: the counter and stable are cleared. The key must be re-qualified for the full 2 + DEBOUNCE_CYCLES after reset_n rises.

Decomposition:
- Shared package key_switch_pkg: address constants ADDR_SW=0, ADDR_KEY=1, ADDR_FLAG=2, ADDR_MASK=3; data width constant DATA_W=8; key count NKEYS=4.
- One sub-module, key_debounce: synchroniser, counter and stable output plus rise pulse, parameterised by DEBOUNCE_CYCLES. Instantiate it four times with a generate loop.
- Switch synchronisers, register file and irq logic stay in key_switch_port.

Test Plan:
- Reset and initial state: hold reset_n=0 for 3 cycles, then release → rdata=0, irq=0. Read addr 1 returns 0x00; read addr 2 returns 0x00.
- Clean press: key_raw[0] goes 0 and holds, with DEBOUNCE_CYCLES=4 → stable[0] rises exactly 6 edges later. Read addr 2 returns 0x01, and the following read of addr 2 returns 0x00.
- Bounce rejection: key_raw[1] pulses low for 3 cycles, high for 2, then low for 3 → addr 1 stays 0x00 and addr 2 stays 0x00.
- Interrupt path: write addr 3 = 0x04, then press key 2 → irq=1 the cycle after flag[2] sets. Write addr 2 = 0x04 → irq=0 after that edge.
- Switch read and set-wins: sw_raw=0xA5 → addr 0 reads 0xA5 after 2 edges. Read addr 2 on the same edge key 3's stable rises → rdata shows the old flags and flag[3] remains 1.
- Async reset mid-debounce: press key 0, assert reset_n=0 between clk edges at debounce count 2 → all outputs are 0 immediately. After release, stable[0] needs the full 6 edges again.
